// File: rtl/student_dma_chain_pkg.sv
// Shared types for the descriptor-chain sequencer: minimal TL-UL structs,
// device register map, STATUS bit positions and the chain FSM encoding.
package student_dma_chain_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Only the low address byte selects a device register.
  localparam int unsigned DevAddrW = 8;
  localparam logic [DevAddrW-1:0] EnqOffset       = 8'h00;
  localparam logic [DevAddrW-1:0] CtrlOffset      = 8'h04;
  localparam logic [DevAddrW-1:0] StatusRegOffset = 8'h08;
  localparam logic [DevAddrW-1:0] DoneCntOffset   = 8'h0C;

  localparam int unsigned CtrlEnableBit     = 0;
  localparam int unsigned CtrlClearBit      = 1;
  localparam int unsigned StatusBusyBit     = 8;
  localparam int unsigned StatusFullBit     = 9;
  localparam int unsigned StatusOverflowBit = 10;
  localparam int unsigned StatusErrorBit    = 11;

  localparam logic [1:0] DmaStatusIdle = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    KICK_SEND,
    KICK_RESP,
    POLL_GAP,
    POLL_SEND,
    POLL_RESP
  } chain_state_t;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with optional pass-through; a write is accepted while full
// when the head is read in the same cycle.
module prim_fifo_sync #(
  parameter int unsigned Width = 16,
  parameter bit          Pass  = 1'b1,
  parameter int unsigned Depth = 4,
  localparam int unsigned DepthW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]  mem [Depth];
  logic [PtrW-1:0]   wptr, rptr;
  logic [DepthW-1:0] cnt;
  logic empty, pass_thru, do_read, do_write, store, drop;

  assign empty     = (cnt == '0);
  assign full_o    = (cnt == DepthW'(Depth));
  assign depth_o   = cnt;
  assign pass_thru = Pass & empty;
  assign rvalid_o  = ~empty | (Pass & wvalid_i);
  assign rdata_o   = pass_thru ? wdata_i : mem[rptr];
  assign wready_o  = ~full_o | rready_i;
  assign do_read   = rvalid_o & rready_i;
  assign do_write  = wvalid_i & wready_o;
  assign store     = do_write & ~(pass_thru & do_read);
  assign drop      = do_read & ~pass_thru;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (store) wptr <= wptr + 1'b1;
      if (drop)  rptr <= rptr + 1'b1;
      cnt <= cnt + DepthW'(store) - DepthW'(drop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem[wptr] <= wdata_i;
  end

endmodule

// File: rtl/student_dma_chain.sv
// Descriptor-chain sequencer: queues descriptor addresses from software and
// kicks student_dma with each one, polling its STATUS until it returns to IDLE.
module student_dma_chain
  import student_dma_chain_pkg::*;
#(
  parameter int unsigned QueueDepth    = 8,
  parameter logic [31:0] DmaBaseAddr   = 32'h0000_0000,
  parameter logic [31:0] NowDadrOffset = 32'h10,
  parameter logic [31:0] StatusOffset  = 32'h00,
  parameter int unsigned PollGap       = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  input  tl_d2h_t tl_host_i,
  output tl_h2d_t tl_host_o,
  output logic    irq_done_o
);

  localparam int unsigned CntW    = $clog2(QueueDepth + 1);
  localparam logic [7:0]  GapLoad = 8'(PollGap);

  chain_state_t state;
  logic        enable, overflow, error, head_held;
  logic [31:0] done_cnt;
  logic        d_valid_q;
  tl_d_op_e    d_opcode_q;
  logic [1:0]  d_size_q;
  logic [7:0]  d_source_q;
  logic [31:0] d_data_q;
  logic        h_valid_q, irq_q;
  tl_a_op_e    h_opcode_q;
  logic [31:0] h_address_q, h_data_q;
  logic [7:0]  gap_q;

  logic                dev_a_ready, dev_req, dev_wr, dev_rd;
  logic [DevAddrW-1:0] dev_addr;
  logic                enq_wr, ctrl_wr, done_wr, clear;
  logic [31:0]         rdata, status_word;
  logic [4:0]          q_count;
  logic                q_full, room, push, overflow_set;
  logic                fifo_wready, fifo_rvalid, fifo_full, fifo_pop;
  logic [31:0]         fifo_rdata;
  logic [CntW-1:0]     fifo_depth;
  logic                done_evt, err_evt, busy;

  assign dev_a_ready = ~d_valid_q | tl_i.d_ready;
  assign dev_req     = tl_i.a_valid & dev_a_ready;
  assign dev_rd      = dev_req & (tl_i.a_opcode == Get);
  assign dev_wr      = dev_req & (tl_i.a_opcode != Get);
  assign dev_addr    = tl_i.a_address[DevAddrW-1:0];
  assign enq_wr      = dev_wr & (dev_addr == EnqOffset);
  assign ctrl_wr     = dev_wr & (dev_addr == CtrlOffset);
  assign done_wr     = dev_wr & (dev_addr == DoneCntOffset);
  assign clear       = ctrl_wr & tl_i.a_data[CtrlClearBit];

  // A head flushed while in flight is still counted until its descriptor finishes.
  assign q_count      = 5'(fifo_depth) + 5'(head_held);
  assign q_full       = (q_count == 5'(QueueDepth));
  assign busy         = (state != IDLE);
  assign room         = ~q_full | done_evt;
  assign push         = enq_wr & room;
  assign overflow_set = enq_wr & ~room;

  assign done_evt = (state == POLL_RESP) & tl_host_i.d_valid & ~tl_host_i.d_error &
                    (tl_host_i.d_data[1:0] == DmaStatusIdle);
  assign err_evt  = ((state == KICK_RESP) | (state == POLL_RESP)) &
                    tl_host_i.d_valid & tl_host_i.d_error;
  assign fifo_pop = done_evt & ~head_held;

  always_comb begin
    status_word                    = '0;
    status_word[4:0]               = q_count;
    status_word[StatusBusyBit]     = busy;
    status_word[StatusFullBit]     = q_full;
    status_word[StatusOverflowBit] = overflow;
    status_word[StatusErrorBit]    = error;
  end

  always_comb begin
    rdata = '0;
    case (dev_addr)
      CtrlOffset:      rdata[CtrlEnableBit] = enable;
      StatusRegOffset: rdata = status_word;
      DoneCntOffset:   rdata = done_cnt;
      default:         rdata = '0;
    endcase
  end

  prim_fifo_sync #(
    .Width (32),
    .Pass  (1'b0),
    .Depth (QueueDepth)
  ) u_queue (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clear),
    .wvalid_i (push),
    .wready_o (fifo_wready),
    .wdata_i  (tl_i.a_data),
    .rvalid_o (fifo_rvalid),
    .rready_i (fifo_pop),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .depth_o  (fifo_depth)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= AccessAck;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
    end else if (dev_req) begin
      d_valid_q  <= 1'b1;
      d_opcode_q <= dev_rd ? AccessAckData : AccessAck;
      d_size_q   <= tl_i.a_size;
      d_source_q <= tl_i.a_source;
      d_data_q   <= dev_rd ? rdata : '0;
    end else if (tl_i.d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  // A sticky flag raised in the same cycle as a clear survives it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable    <= 1'b0;
      overflow  <= 1'b0;
      error     <= 1'b0;
      head_held <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (ctrl_wr) enable <= tl_i.a_data[CtrlEnableBit];
      overflow <= (overflow & ~clear) | overflow_set;
      error    <= (error & ~clear) | err_evt;
      if (clear)                    head_held <= busy & ~done_evt & ~err_evt;
      else if (done_evt | err_evt)  head_held <= 1'b0;
      if (done_wr)       done_cnt <= '0;
      else if (done_evt) done_cnt <= done_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      h_valid_q   <= 1'b0;
      h_opcode_q  <= PutFullData;
      h_address_q <= '0;
      h_data_q    <= '0;
      gap_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && fifo_rvalid && !error) begin
            h_valid_q   <= 1'b1;
            h_opcode_q  <= PutFullData;
            h_address_q <= DmaBaseAddr + NowDadrOffset;
            h_data_q    <= fifo_rdata;
            state       <= KICK_SEND;
          end
        end
        KICK_SEND: begin
          if (tl_host_i.a_ready) begin
            h_valid_q <= 1'b0;
            state     <= KICK_RESP;
          end
        end
        KICK_RESP: begin
          if (tl_host_i.d_valid) begin
            if (tl_host_i.d_error) begin
              state <= IDLE;
            end else begin
              gap_q <= GapLoad;
              state <= POLL_GAP;
            end
          end
        end
        POLL_GAP: begin
          gap_q <= gap_q - 8'd1;
          if (gap_q <= 8'd1) begin
            h_valid_q   <= 1'b1;
            h_opcode_q  <= Get;
            h_address_q <= DmaBaseAddr + StatusOffset;
            h_data_q    <= '0;
            state       <= POLL_SEND;
          end
        end
        POLL_SEND: begin
          if (tl_host_i.a_ready) begin
            h_valid_q <= 1'b0;
            state     <= POLL_RESP;
          end
        end
        POLL_RESP: begin
          if (tl_host_i.d_valid) begin
            if (tl_host_i.d_error) begin
              state <= IDLE;
            end else if (tl_host_i.d_data[1:0] == DmaStatusIdle) begin
              irq_q <= 1'b1;
              state <= IDLE;
            end else begin
              gap_q <= GapLoad;
              state <= POLL_GAP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = 1'b0;
    tl_o.a_ready  = dev_a_ready;
  end

  always_comb begin
    tl_host_o           = '0;
    tl_host_o.a_valid   = h_valid_q;
    tl_host_o.a_opcode  = h_opcode_q;
    tl_host_o.a_size    = 2'd2;
    tl_host_o.a_source  = '0;
    tl_host_o.a_address = h_address_q;
    tl_host_o.a_mask    = 4'hF;
    tl_host_o.a_data    = h_data_q;
    tl_host_o.d_ready   = 1'b1;
  end

  assign irq_done_o = irq_q;

  logic unused_bits;
  assign unused_bits = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_address[31:DevAddrW],
                         tl_host_i.d_opcode, tl_host_i.d_param, tl_host_i.d_size,
                         tl_host_i.d_source, tl_host_i.d_sink, tl_host_i.d_data[31:2],
                         tl_host_i.a_ready, fifo_wready, fifo_full};

endmodule
